// File: rtl/serial_subtractor_32_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package subtractor_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int CNT_W_DEFAULT = $clog2(WIDTH_DEFAULT) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

endpackage

// File: rtl/serial_subtractor_32_if.sv
// Request/result bundle between a requester (master) and the serial subtractor (slave).
interface serial_subtractor_32_if #(
    parameter int WIDTH = subtractor_pkg::WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor_32_full_subtractor.sv
// One-bit full subtractor from gate primitives so the datapath stays gate-level.
module full_subtractor (
    input  wire x,
    input  wire y,
    input  wire bi,
    output wire d,
    output wire bo
);
    wire nx;
    wire xy;
    wire t0;
    wire t1;
    wire t2;

    not u_nx (nx, x);
    xor u_x0 (xy, x, y);
    xor u_x1 (d, xy, bi);
    and u_a0 (t0, nx, y);
    and u_a1 (t1, nx, bi);
    and u_a2 (t2, y, bi);
    or  u_o0 (bo, t0, t1, t2);
endmodule

// File: rtl/serial_subtractor_32.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor cell per clock.
module serial_subtractor_32
    import subtractor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_subtractor_32_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    sub_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q;
    logic             done_q;
    logic             d_s;
    logic             bo_s;

    full_subtractor u_cell (
        .x  (a_q[0]),
        .y  (b_q[0]),
        .bi (br_q),
        .d  (d_s),
        .bo (bo_s)
    );

    // Next-state, datapath shifting and result capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = bus.bin;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                res_d = {d_s, res_q[WIDTH-1:1]};
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                br_d  = bo_s;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    diff_d  = {d_s, res_q[WIDTH-1:1]};
                    bout_d  = bo_s;
                    // On the last bit the operand LSBs are the captured sign bits.
                    ovf_d   = (a_q[0] != b_q[0]) && (d_s != a_q[0]);
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            br_q    <= 1'b0;
            res_q   <= {WIDTH{1'b0}};
            diff_q  <= {WIDTH{1'b0}};
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            busy_q  <= (state_d == SHIFT);
            done_q  <= (state_d == DONE);
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor_32.sv
// Randomized and directed checks of serial_subtractor_32 against an arithmetic reference.
module tb_serial_subtractor_32;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    serial_subtractor_32_if #(.WIDTH(W)) bus ();

    serial_subtractor_32 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         output logic [W-1:0] diff, output logic bout, output logic ovf);
        logic [W:0] ua;
        logic [W:0] ub;
        logic [W:0] r;
        longint     sr;
        ua   = {1'b0, a};
        ub   = {1'b0, b};
        r    = ua - ub - {{W{1'b0}}, bin};
        diff = r[W-1:0];
        bout = (ua < ub + {{W{1'b0}}, bin});
        sr   = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endtask

    // Present operands and pass the accepting edge; scramble inputs afterwards.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input bit immediate);
        if (!immediate) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.bin   = 1'($urandom_range(0, 1));
        check_eq("busy_after_accept", 64'(bus.busy), 64'd1);
        check_eq("done_after_accept", 64'(bus.done), 64'd0);
    endtask

    // Count edges to done and compare the result; poke_at>0 pulses a stray start.
    task automatic finish_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                             input int poke_at);
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
        int           edges;
        edges = 0;
        model(a, b, bin, ed, eb, eo);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.done) break;
            if (edges == poke_at) begin
                bus.start = 1'b1;
                bus.a     = ~a;
                bus.b     = a;
                bus.bin   = ~bin;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check_eq("latency", 64'(edges), 64'd32);
        check_eq("done", 64'(bus.done), 64'd1);
        check_eq("busy_in_done", 64'(bus.busy), 64'd0);
        check_eq("diff", 64'(bus.diff), 64'(ed));
        check_eq("bout", 64'(bus.bout), 64'(eb));
        check_eq("ovf", 64'(bus.ovf), 64'(eo));
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        launch(a, b, bin, 1'b0);
        finish_op(a, b, bin, 0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbin;
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
        int           seen_done;

        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy", 64'(bus.busy), 64'd0);
        check_eq("reset_done", 64'(bus.done), 64'd0);
        check_eq("reset_diff", 64'(bus.diff), 64'd0);
        check_eq("reset_bout_ovf", 64'({bus.bout, bus.ovf}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases; first one also checks pulse width and result hold.
        run_op(32'h0000000A, 32'h00000003, 1'b0);
        @(posedge clk);
        #1;
        check_eq("done_single_pulse", 64'(bus.done), 64'd0);
        check_eq("diff_hold", 64'(bus.diff), 64'h7);
        run_op(32'h00000000, 32'h00000001, 1'b0);
        check_eq("diff_wrap", 64'(bus.diff), 64'hFFFFFFFF);
        run_op(32'h80000000, 32'h00000001, 1'b0);
        check_eq("ovf_neg", 64'(bus.ovf), 64'd1);
        run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0);
        check_eq("diff_ovf_pos", 64'(bus.diff), 64'h80000000);
        run_op(32'd5, 32'd5, 1'b1);
        check_eq("bin_borrow", 64'({bus.bout, bus.diff}), 64'h1FFFFFFFF);

        // Stray start during SHIFT is ignored.
        launch(32'h12345678, 32'h00ABCDEF, 1'b0, 1'b0);
        finish_op(32'h12345678, 32'h00ABCDEF, 1'b0, 10);

        // Back-to-back: start held in the DONE cycle.
        launch(32'h00000100, 32'h00000001, 1'b0, 1'b1);
        finish_op(32'h00000100, 32'h00000001, 1'b0, 0);
        check_eq("b2b_diff", 64'(bus.diff), 64'hFF);

        // Reset mid-operation aborts with no done.
        launch(32'hCAFEF00D, 32'h00001234, 1'b1, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("abort_outputs", 64'({bus.busy, bus.done, bus.bout, bus.ovf}), 64'd0);
        check_eq("abort_diff", 64'(bus.diff), 64'd0);
        seen_done = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done++;
        end
        check_eq("no_done_after_abort", 64'(seen_done), 64'd0);
        run_op(32'hFFFFFFFF, 32'h12345678, 1'b0);
        check_eq("post_reset_diff", 64'(bus.diff), 64'hEDCBA987);

        // Random operations, alternating idle gaps and back-to-back accepts.
        for (int i = 0; i < 24; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rbin = 1'($urandom_range(0, 1));
            if (i % 4 == 1) rb = ra;
            if (i % 3 == 0) begin
                launch(ra, rb, rbin, 1'b1);
            end else begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                launch(ra, rb, rbin, 1'b0);
            end
            finish_op(ra, rb, rbin, 0);
        end

        model(32'h0, 32'h0, 1'b0, ed, eb, eo);
        check_eq("model_sanity_zero", 64'({eb, eo, ed}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
